lstm_output_packetizer: RTL and testbench

- Downstream consumer of the LSTM layer stack's y_out/y_out_valid sample stream.
- Buffers each y sample in a circular FIFO and re-emits it on an AXI4-Stream master, sign-extended to 32 bits.
- Asserts tlast every SEQ_LEN beats so DMA sees one packet per inference sequence.
- The LSTM side has no backpressure, so the block absorbs bursts, drops on full and reports drops via a sticky flag and counter.

---
 rtl/lstm_output_packetizer_pkg.sv | 22 ++
 rtl/lstm_output_packetizer_fifo.sv | 51 +++++
 rtl/lstm_output_packetizer.sv | 152 +++++++++++++++
 tb/tb_lstm_output_packetizer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_output_packetizer_pkg.sv
// Shared stream types and the sign-extension helper for the LSTM output packetizer.
package lstm_stream_package;

  localparam int AXIS_WIDTH = 32;
  localparam int Y_WIDTH    = 16;

  typedef enum logic {IDLE, IN_PKT} pkt_state_t;

  typedef struct packed {
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tlast;
  } axis_beat_t;

  // raw holds a width-bit value zero-extended to AXIS_WIDTH; replicate its top bit.
  function automatic logic [AXIS_WIDTH-1:0] sext_to_axis(input logic [AXIS_WIDTH-1:0] raw,
                                                         input int unsigned width);
    logic signed [AXIS_WIDTH-1:0] tmp;
    tmp = raw << (AXIS_WIDTH - width);
    return tmp >>> (AXIS_WIDTH - width);
  endfunction

endpackage

// File: rtl/lstm_output_packetizer_fifo.sv
// Circular sample buffer: wrap-bit pointers, combinational read of the head entry.
// One write and one read per cycle; no internal backpressure, flush empties it on the next edge.
module lstm_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // When full with a simultaneous pop the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/lstm_output_packetizer.sv
// Buffers LSTM y samples and emits them as sign-extended AXI4-Stream beats with tlast every seq_len beats.
// Latency 1 cycle from y_in_valid to m_tvalid; input cannot stall, so samples arriving while full are dropped.
module lstm_output_packetizer
  import lstm_stream_package::*;
#(
  parameter int DATA_WIDTH    = Y_WIDTH,
  parameter int DEPTH         = 64,
  parameter int SEQ_LEN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEQ_LEN_WIDTH-1:0] seq_len,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    y_in,
  input  logic                     y_in_valid,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic [15:0]              drop_count,
  output logic [15:0]              packet_count
);

  localparam logic [SEQ_LEN_WIDTH-1:0] LEN_ONE = SEQ_LEN_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [SEQ_LEN_WIDTH-1:0] seq_len_eff;

  pkt_state_t               state_q, state_d;
  logic [SEQ_LEN_WIDTH-1:0] beat_q, beat_d;
  logic [SEQ_LEN_WIDTH-1:0] len_q, len_d;
  logic                     tlast_c;
  logic                     pkt_done;
  axis_beat_t               beat_out;

  assign pop         = m_tvalid && m_tready;
  assign push        = y_in_valid && (!full || pop);
  assign drop        = y_in_valid && full && !pop && !flush;
  assign seq_len_eff = (seq_len == '0) ? LEN_ONE : seq_len;

  lstm_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (y_in),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign m_tvalid = !empty;

  // Beat fields are forced to zero while nothing is buffered.
  always_comb begin
    beat_out.tdata = '0;
    beat_out.tlast = 1'b0;
    if (m_tvalid) begin
      beat_out.tdata = sext_to_axis(AXIS_WIDTH'(rd_data), DATA_WIDTH);
      beat_out.tlast = tlast_c;
    end
  end

  assign m_tdata = beat_out.tdata;
  assign m_tlast = beat_out.tlast;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    tlast_c  = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        tlast_c = (seq_len_eff == LEN_ONE);
        if (pop) begin
          len_d = seq_len_eff;
          if (tlast_c) begin
            pkt_done = 1'b1;
          end else begin
            state_d = IN_PKT;
            beat_d  = LEN_ONE;
          end
        end
      end
      IN_PKT: begin
        tlast_c = (beat_q == len_q - LEN_ONE);
        if (pop) begin
          if (tlast_c) begin
            state_d  = IDLE;
            beat_d   = '0;
            pkt_done = 1'b1;
          end else begin
            beat_d = beat_q + LEN_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flush abandons the packet in progress without counting it.
    if (flush) begin
      state_d  = IDLE;
      beat_d   = '0;
      pkt_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      len_q        <= '0;
      packet_count <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      if (pkt_done) packet_count <= packet_count + 16'd1;
    end
  end

  // A drop in the same cycle as clear_overflow wins and restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)              drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_lstm_output_packetizer.sv
// Directed bench for lstm_output_packetizer: queue-based reference model checked every cycle plus literal checks.
module tb_lstm_output_packetizer;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int SLW   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [SLW-1:0] seq_len = 16'd4;
  logic           flush = 1'b0;
  logic [DW-1:0]  y_in = '0;
  logic           y_in_valid = 1'b0;
  logic [31:0]    m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic           m_tlast;
  logic [6:0]     level;
  logic           overflow;
  logic           clear_overflow = 1'b0;
  logic [15:0]    drop_count;
  logic [15:0]    packet_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lstm_output_packetizer #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .SEQ_LEN_WIDTH (SLW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .seq_len        (seq_len),
    .flush          (flush),
    .y_in           (y_in),
    .y_in_valid     (y_in_valid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count),
    .packet_count   (packet_count)
  );

  // Reference model: sample queue, position within the current packet, counters.
  logic [15:0] mq[$];
  int          m_beat  = 0;
  int          m_len   = 1;
  int          m_pkts  = 0;
  int          m_drops = 0;
  bit          m_ovf   = 1'b0;

  logic [31:0] log_data[$];
  bit          log_last[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic int eff_len(input logic [15:0] s);
    return (s == 16'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [31:0] log_d(input int i);
    return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_l(input int i);
    return (i < log_last.size()) ? 32'(log_last[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic model_cycle();
    bit exp_valid;
    bit exp_last;
    bit mpop;
    bit mdrop;
    if (!rst) begin
      mq.delete();
      m_beat  = 0;
      m_len   = 1;
      m_pkts  = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
    end
    exp_valid = (mq.size() != 0);
    exp_last  = 1'b0;
    check("tvalid", 32'(m_tvalid), 32'(exp_valid));
    check("level", 32'(level), mq.size());
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), m_drops);
    check("packet_count", 32'(packet_count), m_pkts);
    if (exp_valid) begin
      exp_last = (m_beat == 0) ? (eff_len(seq_len) == 1) : (m_beat == m_len - 1);
      check("tdata", m_tdata, sext16(mq[0]));
      check("tlast", 32'(m_tlast), 32'(exp_last));
    end
    if (rst) begin
      if (m_tvalid && m_tready) begin
        log_data.push_back(m_tdata);
        log_last.push_back(m_tlast);
      end
      mpop  = exp_valid && m_tready;
      mdrop = 1'b0;
      if (flush) begin
        mq.delete();
        m_beat = 0;
      end else begin
        if (mpop) begin
          if (m_beat == 0) m_len = eff_len(seq_len);
          void'(mq.pop_front());
          if (exp_last) begin
            m_pkts = (m_pkts + 1) & 16'hFFFF;
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
        if (y_in_valid) begin
          if (mq.size() < DEPTH) mq.push_back(y_in);
          else mdrop = 1'b1;
        end
      end
      if (mdrop) begin
        m_ovf   = 1'b1;
        m_drops = clear_overflow ? 1 : ((m_drops < 16'hFFFF) ? m_drops + 1 : m_drops);
      end else if (clear_overflow) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] v);
    y_in       = v;
    y_in_valid = 1'b1;
    step();
    y_in_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drops", 32'(drop_count), 0);
    check("rst_pkts", 32'(packet_count), 0);
    rst = 1'b1;
    step(2);

    // seq_len=4, eight spaced samples
    m_tready = 1'b1;
    seq_len  = 16'd4;
    log_data.delete(); log_last.delete();
    for (int i = 1; i <= 8; i++) send(16'(i));
    step(3);
    check("t1_beats", log_data.size(), 8);
    check("t1_d0", log_d(0), 32'h1);
    check("t1_d7", log_d(7), 32'h8);
    check("t1_last0", log_l(0), 0);
    check("t1_last3", log_l(3), 1);
    check("t1_last6", log_l(6), 0);
    check("t1_last7", log_l(7), 1);
    check("t1_pkts", 32'(packet_count), 2);

    // seq_len=0 behaves as 1; sign extension
    seq_len = 16'd0;
    log_data.delete(); log_last.delete();
    send(16'h8000);
    send(16'h7FFF);
    send(16'h0003);
    step(2);
    check("t2_beats", log_data.size(), 3);
    check("t2_d0", log_d(0), 32'hFFFF8000);
    check("t2_d1", log_d(1), 32'h00007FFF);
    check("t2_last0", log_l(0), 1);
    check("t2_last1", log_l(1), 1);
    check("t2_last2", log_l(2), 1);
    check("t2_pkts", 32'(packet_count), 5);

    // overflow: DEPTH+3 back-to-back with no ready
    seq_len  = 16'd4;
    m_tready = 1'b0;
    log_data.delete(); log_last.delete();
    y_in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      y_in = 16'(16'h0100 + i);
      step();
    end
    y_in_valid = 1'b0;
    step();
    check("t3_level", 32'(level), DEPTH);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_drops", 32'(drop_count), 3);
    y_in = 16'h01FF; y_in_valid = 1'b1; clear_overflow = 1'b1;
    step();
    y_in_valid = 1'b0; clear_overflow = 1'b0;
    check("t3_clr_drop_ovf", 32'(overflow), 1);
    check("t3_clr_drop_cnt", 32'(drop_count), 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("t3_clr_ovf", 32'(overflow), 0);
    check("t3_clr_cnt", 32'(drop_count), 0);
    m_tready = 1'b1;
    step(70);
    check("t3_beats", log_data.size(), DEPTH);
    check("t3_d0", log_d(0), 32'h100);
    check("t3_d63", log_d(63), 32'h13F);
    check("t3_last63", log_l(63), 1);
    check("t3_pkts", 32'(packet_count), 21);

    // full with simultaneous push and pop
    m_tready = 1'b0;
    log_data.delete(); log_last.delete();
    y_in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      y_in = 16'(16'h0200 + i);
      step();
    end
    y_in = 16'h02AA; m_tready = 1'b1;
    step();
    y_in_valid = 1'b0; m_tready = 1'b0;
    check("t4_level", 32'(level), DEPTH);
    check("t4_drops", 32'(drop_count), 0);
    check("t4_ovf", 32'(overflow), 0);
    m_tready = 1'b1;
    step(70);
    check("t4_beats", log_data.size(), DEPTH + 1);
    check("t4_d0", log_d(0), 32'h200);
    check("t4_d64", log_d(64), 32'h2AA);
    check("t4_pkts", 32'(packet_count), 37);

    // flush ends the open packet and discards buffered/incoming samples
    flush = 1'b1;
    step();
    flush = 1'b0;
    log_data.delete(); log_last.delete();
    send(16'h0301);
    send(16'h0302);
    m_tready = 1'b0;
    send(16'h0303);
    send(16'h0304);
    check("t5_level_pre", 32'(level), 2);
    flush = 1'b1; y_in = 16'h03FF; y_in_valid = 1'b1;
    step();
    flush = 1'b0; y_in_valid = 1'b0;
    check("t5_level", 32'(level), 0);
    check("t5_tvalid", 32'(m_tvalid), 0);
    check("t5_drops", 32'(drop_count), 0);
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'(16'h0400 + i));
    step(2);
    check("t5_beats", log_data.size(), 6);
    check("t5_d1", log_d(1), 32'h302);
    check("t5_last1", log_l(1), 0);
    check("t5_d2", log_d(2), 32'h401);
    check("t5_last4", log_l(4), 0);
    check("t5_last5", log_l(5), 1);
    check("t5_pkts", 32'(packet_count), 38);

    // asynchronous reset mid-packet
    log_data.delete(); log_last.delete();
    send(16'h0501);
    send(16'h0502);
    m_tready = 1'b0;
    for (int i = 3; i <= 7; i++) send(16'(16'h0500 + i));
    check("t6_level_pre", 32'(level), 5);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 0);
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_pkts", 32'(packet_count), 0);
    check("t6_rst_tlast", 32'(m_tlast), 0);
    step(2);
    rst = 1'b1;
    step();
    m_tready = 1'b1;
    log_data.delete(); log_last.delete();
    for (int i = 1; i <= 4; i++) send(16'(16'h0600 + i));
    step(2);
    check("t6_beats", log_data.size(), 4);
    check("t6_last2", log_l(2), 0);
    check("t6_last3", log_l(3), 1);
    check("t6_pkts", 32'(packet_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
